// File: rtl/ocs_2x2_guard_sw.sv
// Registered 2x2 optical circuit switch cell (BAR/CROSS) with guard-interval blanking on reconfiguration.
// Optional saturating reconfiguration counter on o_recfg_cnt when OCS_RECFG_CNT_EN is defined.
module ocs_2x2_guard_sw #(
    parameter int   P_DATA_WIDTH   = 3,
    parameter logic P_BAR          = 1'b0,
    parameter logic P_CROSS        = 1'b1,
    parameter int   P_GUARD_CYCLES = 4,
    parameter int   P_CNT_WIDTH    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cfg_valid,
    input  logic                      i_cfg_grant,
    output logic                      o_cfg_ready,
    input  logic [1:0]                i_valid,
    input  logic [2*P_DATA_WIDTH-1:0] i_data,
    output logic [1:0]                o_valid,
    output logic [2*P_DATA_WIDTH-1:0] o_data,
    output logic                      o_grant,
    output logic                      o_guard
`ifdef OCS_RECFG_CNT_EN
    ,
    output logic [P_CNT_WIDTH-1:0]    o_recfg_cnt
`endif
);

    localparam int W = P_DATA_WIDTH;
    localparam logic [7:0] GUARD_LOAD = 8'(P_GUARD_CYCLES - 1);

    generate
        if (P_GUARD_CYCLES < 1 || P_GUARD_CYCLES > 255 || P_CNT_WIDTH < 1) begin : g_bad_param
            $error("ocs_2x2_guard_sw: illegal parameter value");
        end
    endgenerate

    typedef enum logic {S_RUN, S_GUARD} state_t;

    state_t     state_q, state_d;
    logic [7:0] guard_cnt_q, guard_cnt_d;
    logic       pending_q, pending_d;
    logic       grant_q, grant_d;
    logic       accept, change, guard_done, pass;

    // Handshake: a request transfers on a rising edge with i_cfg_valid & o_cfg_ready;
    // i_cfg_grant is sampled only then, and valid while ready is low is ignored.
    assign o_cfg_ready = (state_q == S_RUN);
    assign accept      = i_cfg_valid & o_cfg_ready;
    assign change      = accept & (i_cfg_grant != grant_q);
    assign pass        = (state_q == S_RUN) & ~change;
    assign o_guard     = (state_q == S_GUARD);
    assign o_grant     = grant_q;

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        pending_d   = pending_q;
        grant_d     = grant_q;
        guard_done  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (change) begin
                    pending_d   = i_cfg_grant;
                    guard_cnt_d = GUARD_LOAD;
                    state_d     = S_GUARD;
                end
            end
            S_GUARD: begin
                if (guard_cnt_q == 8'd0) begin
                    grant_d    = pending_q;
                    state_d    = S_RUN;
                    guard_done = 1'b1;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_RUN;
            guard_cnt_q <= 8'd0;
            pending_q   <= P_BAR;
            grant_q     <= P_BAR;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            pending_q   <= pending_d;
            grant_q     <= grant_d;
        end
    end

    // Datapath routes with the grant in force at this edge; blanked from E0 through guard expiry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 2'b00;
            o_data  <= '0;
        end else if (pass) begin
            if (grant_q == P_CROSS) begin
                o_valid <= {i_valid[0], i_valid[1]};
                o_data  <= {i_data[W-1:0], i_data[2*W-1:W]};
            end else begin
                o_valid <= i_valid;
                o_data  <= i_data;
            end
        end else begin
            o_valid <= 2'b00;
            o_data  <= '0;
        end
    end

`ifdef OCS_RECFG_CNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_recfg_cnt <= '0;
        end else if (guard_done && (o_recfg_cnt != {P_CNT_WIDTH{1'b1}})) begin
            o_recfg_cnt <= o_recfg_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ocs_2x2_guard_sw.sv
// Bench for ocs_2x2_guard_sw: directed vector table, hand sequences for guard corners, random traffic vs model.
// Covers OCS_RECFG_CNT_EN checks when the macro is defined.
module tb_ocs_2x2_guard_sw;

    localparam int W  = 3;
    localparam int G  = 4;
    localparam int CW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_grant = 1'b0;
    logic           cfg_ready;
    logic [1:0]     in_valid = 2'b00;
    logic [2*W-1:0] in_data = '0;
    logic [1:0]     out_valid;
    logic [2*W-1:0] out_data;
    logic           grant;
    logic           guard;
`ifdef OCS_RECFG_CNT_EN
    logic [CW-1:0]  recfg_cnt;
`endif

    always #5 clk = ~clk;

    ocs_2x2_guard_sw #(
        .P_DATA_WIDTH  (W),
        .P_BAR         (1'b0),
        .P_CROSS       (1'b1),
        .P_GUARD_CYCLES(G),
        .P_CNT_WIDTH   (CW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cfg_valid(cfg_valid),
        .i_cfg_grant(cfg_grant),
        .o_cfg_ready(cfg_ready),
        .i_valid    (in_valid),
        .i_data     (in_data),
        .o_valid    (out_valid),
        .o_data     (out_data),
        .o_grant    (grant),
        .o_guard    (guard)
`ifdef OCS_RECFG_CNT_EN
        ,
        .o_recfg_cnt(recfg_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: grant in force, pending grant, guard cycles still to run, completed changes.
    logic m_grant   = 1'b0;
    logic m_pending = 1'b0;
    int   m_left    = 0;
    int   m_cnt     = 0;
    logic [2*W+3:0] exp_q[$];

    typedef struct {
        logic           cv;
        logic           cg;
        logic [1:0]     v;
        logic [2*W-1:0] d;
        logic [1:0]     ev;
        logic [2*W-1:0] ed;
        logic           eg;
        logic           eguard;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output port p takes lane (p xor grant); valid travels with its data.
    function automatic logic [2*W+1:0] route(input logic g, input logic [1:0] v, input logic [2*W-1:0] d);
        logic [1:0]   ov;
        logic [W-1:0] od [2];
        for (int p = 0; p < 2; p++) begin
            int src;
            src   = p ^ int'(g);
            ov[p] = v[src];
            od[p] = d[src*W +: W];
        end
        return {ov, od[1], od[0]};
    endfunction

    task automatic model_reset();
        m_grant = 1'b0;
        m_left  = 0;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    // Drive one cycle at the negedge, advance the model at the posedge, compare at the next negedge.
    task automatic step(input logic cv, input logic cg, input logic [1:0] v, input logic [2*W-1:0] d);
        logic [2*W+3:0] e;
        cfg_valid = cv;
        cfg_grant = cg;
        in_valid  = v;
        in_data   = d;
        #1;
        chk("cfg_ready", 32'(cfg_ready), 32'(m_left == 0));
        @(posedge clk);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_grant = m_pending;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
            e = {m_grant, (m_left > 0), 2'b00, {2*W{1'b0}}};
        end else if (cv && (cg != m_grant)) begin
            m_pending = cg;
            m_left    = G;
            e = {m_grant, 1'b1, 2'b00, {2*W{1'b0}}};
        end else begin
            e = {m_grant, 1'b0, route(m_grant, v, d)};
        end
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(e[2*W+3]));
        chk("guard", 32'(guard), 32'(e[2*W+2]));
        chk("o_valid", 32'(out_valid), 32'(e[2*W+1:2*W]));
        chk("o_data", 32'(out_data), 32'(e[2*W-1:0]));
`ifdef OCS_RECFG_CNT_EN
        chk("recfg_cnt", 32'(recfg_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        int gcount;

        vecs[0] = '{1'b0, 1'b0, 2'b11, {3'h2, 3'h5}, 2'b11, {3'h2, 3'h5}, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'b11, {3'h3, 3'h4}, 2'b00, 6'h00,       1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 2'b11, {3'h1, 3'h6}, 2'b00, 6'h00,       1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 2'b11, {3'h1, 3'h6}, 2'b00, 6'h00,       1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 2'b11, {3'h1, 3'h6}, 2'b00, 6'h00,       1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 2'b11, {3'h1, 3'h6}, 2'b00, 6'h00,       1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 2'b11, {3'h4, 3'h3}, 2'b11, {3'h3, 3'h4}, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'b01, {3'h1, 3'h7}, 2'b10, {3'h7, 3'h1}, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 2'b10, {3'h6, 3'h0}, 2'b01, {3'h0, 3'h6}, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_guard", 32'(guard), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        model_reset();

        // Directed table: reset release, change to CROSS, no-op request, per-lane routing
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].cv, vecs[i].cg, vecs[i].v, vecs[i].d);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(vecs[i].eg));
            chk($sformatf("tbl%0d_guard", i), 32'(guard), 32'(vecs[i].eguard));
        end

        // Request held through a guard is taken on the first ready cycle and runs a second guard
        step(1'b1, 1'b0, 2'b11, 6'h15);
        gcount = 1;
        for (int i = 0; i < 40; i++) begin
            if (grant == 1'b1 && !guard) break;
            step(1'b1, 1'b1, 2'b11, 6'(i));
            if (guard) gcount++;
        end
        chk("held_guard_cycles", 32'(gcount), 32'(2 * G));
        chk("held_final_grant", 32'(grant), 32'h1);
        step(1'b0, 1'b0, 2'b11, 6'h2a);

        // Asynchronous reset two cycles into a guard discards the pending grant
        step(1'b1, 1'b0, 2'b11, 6'h11);
        step(1'b0, 1'b0, 2'b11, 6'h22);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_guard", 32'(guard), 32'h0);
        chk("arst_ready", 32'(cfg_ready), 32'h1);
`ifdef OCS_RECFG_CNT_EN
        chk("arst_cnt", 32'(recfg_cnt), 32'h0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < G + 2; i++) begin
            step(1'b0, 1'b0, 2'b11, {3'h6, 3'h1});
            chk("arst_no_apply", 32'(grant), 32'h0);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        end

`ifdef OCS_RECFG_CNT_EN
        // Drive enough real changes to reach saturation
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ~grant, 2'b11, 6'h0);
            for (int j = 0; j < G; j++) step(1'b0, 1'b0, 2'b11, 6'h0);
        end
        chk("cnt_saturated", 32'(recfg_cnt), 32'((1 << CW) - 1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ocs_2x2_guard_sw.md
Name: ocs_2x2_guard_sw

Overview:
- Registered, parametrised 2x2 optical circuit switch cell. It routes two data lanes in BAR or CROSS configuration.
- Reconfiguration requests arrive over a valid/ready handshake.
- Every real configuration change inserts a guard interval. During the guard the outputs are blanked to model optical switch settling time.
- This cell is the building block for the larger Benes/Clos OCS fabrics. The schedule controller drives the cfg port.

Parameters:
- P_DATA_WIDTH, 3: width of one lane.
- P_BAR, 1'b0: grant encoding for BAR (lane0->out0, lane1->out1).
- P_CROSS, 1'b1: grant encoding for CROSS (lane0->out1, lane1->out0).
- P_GUARD_CYCLES, 4: guard length in clocks. Legal range is 1 to 255.
- P_CNT_WIDTH, 16: width of the optional reconfiguration counter.

Ports:
- i_clk, input, 1: sole clock.
- i_rst, input, 1: asynchronous, active-high reset.
- i_cfg_valid, input, 1: reconfiguration request valid.
- i_cfg_grant, input, 1: requested grant (P_BAR or P_CROSS).
- o_cfg_ready, output, 1: request can be accepted.
- i_valid, input, 2: per-lane input valid. Bit k belongs to lane k.
- i_data, input, 2*P_DATA_WIDTH: lane k occupies bits [k*W +: W].
- o_valid, output, 2: per-output-port valid, registered.
- o_data, output, 2*P_DATA_WIDTH: per-output-port data, registered.
- o_grant, output, 1: grant currently applied to the datapath.
- o_guard, output, 1: high while the guard interval is in progress.
- o_recfg_cnt, output, P_CNT_WIDTH: present only with OCS_RECFG_CNT_EN.

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - state=S_RUN
  - o_grant=P_BAR
  - o_valid=0, o_data=0
  - o_guard=0
  - guard counter=0
  - o_recfg_cnt=0
- o_cfg_ready is combinational and equals (state==S_RUN). It is therefore 1 immediately after reset.
- Handshake: a request is accepted on a rising edge where i_cfg_valid & o_cfg_ready. i_cfg_grant is sampled only at that edge. The requester must hold valid and grant stable until accepted. i_cfg_valid while ready=0 is ignored.
- State S_RUN:
  - Accepted request with i_cfg_grant==o_grant: no-op. Stay in S_RUN, no blanking, no data loss, counter unchanged.
  - Accepted request with i_cfg_grant!=o_grant (call this edge E0): latch the pending grant, load guard counter=P_GUARD_CYCLES-1, go to S_GUARD.
- State S_GUARD:
  - o_guard=1 and o_cfg_ready=0.
  - Counter decrements each edge.
  - On the edge where the counter==0 (edge E_G = E0+P_GUARD_CYCLES): o_grant<=pending, state<=S_RUN, o_recfg_cnt increments.
- Datapath, evaluated on every edge:
  - If state==S_RUN and no changing request is accepted at this edge, register the routed inputs:
    - o_grant==P_BAR: out0<=lane0, out1<=lane1.
    - o_grant==P_CROSS: out0<=lane1, out1<=lane0.
    - Valid bits are routed with their data.
  - Otherwise load o_valid=0 and o_data=0.
  - Latency is 1 clock from input to output.
- Consequences of a change accepted at E0:
  - Input samples at E0..E_G are dropped (P_GUARD_CYCLES+1 samples).
  - o_valid is 0 for P_GUARD_CYCLES+1 cycles.
  - o_guard is high for exactly P_GUARD_CYCLES cycles.
  - The first routed output using the new grant appears after E_G+1.
- Data are passed as-is when the matching valid bit is 0; only valid-qualified output data is meaningful. During the guard, data is forced to 0.
- A request arriving in the same cycle that the guard ends sees ready=0 and is accepted on the next edge.
- Reset asserted mid-guard aborts the change. o_grant returns to P_BAR and the pending grant is discarded.

Optional Feature:
- Macro OCS_RECFG_CNT_EN.
- When defined:
  - Port o_recfg_cnt exists.
  - It counts completed reconfigurations (guard expiries only, not no-op requests).
  - It saturates at all-ones.
  - It is cleared by reset.
- When undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset release with i_valid=2'b11, lane0=3'h5, lane1=3'h2 -> one cycle later o_valid=2'b11, out0=5, out1=2, o_grant=0, o_cfg_ready=1.
2. With P_GUARD_CYCLES=4, request grant=1 at E0 while streaming valid data:
   - o_guard high for 4 cycles, o_cfg_ready low for 4 cycles.
   - o_valid low for 5 cycles.
   - Then out0=lane1, out1=lane0, o_grant=1.
   - o_recfg_cnt=1.
3. While o_grant=1, request grant=1 -> accepted same edge, no blanking, o_guard stays 0, o_recfg_cnt unchanged.
4. Hold i_cfg_valid=1 with grant=0 across the whole guard of a prior change -> second request accepted on the first cycle ready=1. A second guard of 4 cycles follows, ending with o_grant=0 and o_recfg_cnt=2.
5. Assert i_rst asynchronously 2 cycles into a guard -> outputs clear immediately, o_grant=0, o_guard=0, o_cfg_ready=1. The pending grant is never applied.
6. Per-lane valid routing: i_valid=2'b01 under CROSS -> o_valid=2'b10. With the macro defined, force 2^P_CNT_WIDTH reconfigurations (P_CNT_WIDTH=2) -> o_recfg_cnt saturates at 3.
